// File: rtl/eth_recv_pkg.sv
// Shared constants, register map and receiver state type for the Ethernet SPI receiver.
package eth_recv_pkg;

  localparam logic [15:0] CR_ADDR     = 16'hFB00;
  localparam logic [15:0] LEN_LO_ADDR = 16'hFB02;
  localparam logic [15:0] LEN_HI_ADDR = 16'hFB03;
  localparam logic [15:0] BUF_BASE    = 16'hF000;

  localparam logic [7:0] FULL_MASK  = 8'h01;
  localparam logic [7:0] BCAST_BYTE = 8'hFF;
  localparam int         ADDR_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  // Byte idx of a station address; byte 0 is the first one on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] shifted;
    shifted = mac << (6'(idx) * 6'd8);
    return shifted[47:40];
  endfunction

endpackage

// File: rtl/eth_spi_rx.sv
// SPI slave front end: 2-flop synchronizers on sck/mosi/ss and an LSB-first byte deserializer.
module eth_spi_rx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       n_ss,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end
);

  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [1:0] ss_sync;
  logic       sck_prev;
  logic       ss_prev;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync    <= 2'b00;
      mosi_sync   <= 2'b00;
      ss_sync     <= 2'b11;
      sck_prev    <= 1'b0;
      ss_prev     <= 1'b1;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      rx_byte     <= 8'h00;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      sck_sync    <= {sck_sync[0], sck};
      mosi_sync   <= {mosi_sync[0], mosi};
      ss_sync     <= {ss_sync[0], n_ss};
      sck_prev    <= sck_sync[1];
      ss_prev     <= ss_sync[1];
      frame_start <= ss_prev & ~ss_sync[1];
      frame_end   <= ~ss_prev & ss_sync[1];
      byte_valid  <= 1'b0;
      // Holding the counter clear while ss is high discards any partial byte.
      if (ss_sync[1] || ss_prev) begin
        bit_cnt <= 3'd0;
      end else if (sck_sync[1] && !sck_prev) begin
        shift   <= {mosi_sync[1], shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= {mosi_sync[1], shift[7:1]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_receiver_system.sv
// Ethernet frame receiver: SPI in, address filter, 2^BUF_AW byte buffer and CPU register window.
// Define ETH_RECV_BROADCAST_EN to also accept frames addressed to FF:FF:FF:FF:FF:FF.
module eth_receiver_system
  import eth_recv_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'hFEFAF6F2EEEA,
  parameter int          BUF_AW   = 11
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        recv_sck,
  input  logic        recv_mosi,
  input  logic        n_recv_ss,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        n_oe,
  input  logic        n_we,
  output logic        n_rdy
);

  localparam int DEPTH = 1 << BUF_AW;
`ifdef ETH_RECV_BROADCAST_EN
  localparam logic BCAST_EN = 1'b1;
`else
  localparam logic BCAST_EN = 1'b0;
`endif

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_end;

  eth_spi_rx u_spi_rx (
    .clk         (clk),
    .n_rst       (n_rst),
    .sck         (recv_sck),
    .mosi        (recv_mosi),
    .n_ss        (n_recv_ss),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  rx_state_t     state_reg;
  logic [BUF_AW:0] byte_cnt_reg;
  logic          mac_live_reg;
  logic          bc_live_reg;
  logic          full_reg;
  logic [15:0]   len_reg;

  logic [1:0]    oe_sync;
  logic [1:0]    we_sync;
  logic          we_prev;

  logic          mac_hit;
  logic          bc_hit;
  logic          wr_en;
  logic          frame_done;
  logic          clear_full;

  logic [7:0]    buffer [DEPTH];
  logic [7:0]    mem_q;
  logic [7:0]    reg_q;
  logic          buf_sel_q;
  logic          buf_hit;
  logic          decode;
  logic [7:0]    d_out;

  assign mac_hit    = mac_live_reg && (rx_byte == mac_byte(MAC_ADDR, byte_cnt_reg[2:0]));
  assign bc_hit     = BCAST_EN && bc_live_reg && (rx_byte == BCAST_BYTE);
  assign wr_en      = byte_valid && !full_reg && !byte_cnt_reg[BUF_AW] &&
                      (state_reg == ST_ADDR || state_reg == ST_DATA);
  assign frame_done = frame_end && (state_reg == ST_DATA);
  assign clear_full = we_prev && !we_sync[1] && (a == CR_ADDR) && ((d & FULL_MASK) == 8'h00);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= '0;
      mac_live_reg <= 1'b0;
      bc_live_reg  <= 1'b0;
      len_reg      <= 16'h0000;
    end else if (frame_start) begin
      byte_cnt_reg <= '0;
      mac_live_reg <= 1'b1;
      bc_live_reg  <= BCAST_EN;
      state_reg    <= full_reg ? ST_DROP : ST_ADDR;
    end else if (frame_end) begin
      if (state_reg == ST_DATA) len_reg <= 16'(byte_cnt_reg) - 16'd1;
      state_reg <= ST_IDLE;
    end else if (byte_valid && (state_reg == ST_ADDR || state_reg == ST_DATA)) begin
      if (byte_cnt_reg[BUF_AW]) begin
        state_reg <= ST_DROP;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
        if (state_reg == ST_ADDR) begin
          mac_live_reg <= mac_hit;
          bc_live_reg  <= bc_hit;
          if (!mac_hit && !bc_hit)
            state_reg <= ST_DROP;
          else if (byte_cnt_reg == (BUF_AW+1)'(ADDR_BYTES - 1))
            state_reg <= ST_DATA;
        end
      end
    end
  end

  // Frame completion takes priority over a simultaneous CPU clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full_reg <= 1'b0;
    end else if (frame_done) begin
      full_reg <= 1'b1;
    end else if (clear_full) begin
      full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      oe_sync <= 2'b11;
      we_sync <= 2'b11;
      we_prev <= 1'b1;
    end else begin
      oe_sync <= {oe_sync[0], n_oe};
      we_sync <= {we_sync[0], n_we};
      we_prev <= we_sync[1];
    end
  end

  assign n_rdy = oe_sync[1] & we_sync[1];

  always_ff @(posedge clk) begin
    if (wr_en) buffer[byte_cnt_reg[BUF_AW-1:0]] <= rx_byte;
    mem_q <= buffer[a[BUF_AW-1:0]];
  end

  assign buf_hit = (a[15:BUF_AW] == BUF_BASE[15:BUF_AW]);
  assign decode  = buf_hit || (a == CR_ADDR) || (a == LEN_LO_ADDR) || (a == LEN_HI_ADDR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reg_q     <= 8'h00;
      buf_sel_q <= 1'b0;
    end else begin
      buf_sel_q <= buf_hit;
      case (a)
        CR_ADDR:     reg_q <= full_reg ? FULL_MASK : 8'h00;
        LEN_LO_ADDR: reg_q <= len_reg[7:0];
        LEN_HI_ADDR: reg_q <= len_reg[15:8];
        default:     reg_q <= 8'h00;
      endcase
    end
  end

  assign d_out = buf_sel_q ? mem_q : reg_q;
  assign d     = (!n_oe && decode) ? d_out : 8'hzz;

endmodule

// File: tb/tb_eth_receiver_system.sv
// Directed bench: SPI frames in, CPU register/buffer reads checked against hand-computed values.
module tb_eth_receiver_system;

  logic        clk;
  logic        n_rst;
  logic        recv_sck;
  logic        recv_mosi;
  logic        n_recv_ss;
  logic [15:0] a;
  wire  [7:0]  d;
  logic        n_oe;
  logic        n_we;
  logic        n_rdy;

  logic        tb_drive;
  logic [7:0]  tb_d;

  int n_checks;
  int n_fail;

`ifdef ETH_RECV_BROADCAST_EN
  localparam logic BCAST = 1'b1;
`else
  localparam logic BCAST = 1'b0;
`endif

  assign d = tb_drive ? tb_d : 8'hzz;

  eth_receiver_system dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .recv_sck  (recv_sck),
    .recv_mosi (recv_mosi),
    .n_recv_ss (n_recv_ss),
    .a         (a),
    .d         (d),
    .n_oe      (n_oe),
    .n_we      (n_we),
    .n_rdy     (n_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic wait_rdy(input logic lvl);
    for (int i = 0; i < 20 && n_rdy !== lvl; i++) @(negedge clk);
    if (n_rdy !== lvl) check("rdy_timeout", {15'd0, n_rdy}, {15'd0, lvl});
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [7:0] val);
    a    = addr;
    n_oe = 1'b0;
    wait_rdy(1'b0);
    @(negedge clk);
    val  = d;
    n_oe = 1'b1;
    wait_rdy(1'b1);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] val);
    a        = addr;
    tb_d     = val;
    tb_drive = 1'b1;
    n_we     = 1'b0;
    wait_rdy(1'b0);
    @(negedge clk);
    n_we     = 1'b1;
    wait_rdy(1'b1);
    tb_drive = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      recv_mosi = b[i];
      #40 recv_sck = 1'b1;
      #40 recv_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] fr [16], input int n);
    n_recv_ss = 1'b0;
    #200;
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    #200 n_recv_ss = 1'b1;
    #300;
  endtask

  logic [7:0] f_uni [16];
  logic [7:0] f_bc  [16];
  logic [7:0] f_oth [16];
  logic [7:0] f_two [16];
  logic [7:0] rd;

  initial begin
    f_uni = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'hAA, 8'h55,
              8'h73, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    f_bc  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAA, 8'h55,
              8'h73, 8'h87, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    f_oth = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h55,
              8'h73, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    f_two = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'h11, 8'h22,
              8'h33, 8'h44, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00};
    n_checks  = 0;
    n_fail    = 0;
    n_rst     = 1'b0;
    recv_sck  = 1'b0;
    recv_mosi = 1'b0;
    n_recv_ss = 1'b1;
    a         = 16'h0000;
    n_oe      = 1'b1;
    n_we      = 1'b1;
    tb_drive  = 1'b0;
    tb_d      = 8'h00;
    #37 n_rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rdy_after_reset", {15'd0, n_rdy}, 16'h0001);
    cpu_read(16'hFB00, rd); check("cr_after_reset", {8'd0, rd}, 16'h0000);
    cpu_read(16'hFB02, rd); check("len_lo_after_reset", {8'd0, rd}, 16'h0000);

    send_frame(f_uni, 10);
    cpu_read(16'hFB00, rd); check("cr_unicast", {8'd0, rd}, 16'h0001);
    cpu_read(16'hFB02, rd); check("len_lo_unicast", {8'd0, rd}, 16'h0009);
    cpu_read(16'hFB03, rd); check("len_hi_unicast", {8'd0, rd}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      cpu_read(16'hF000 + 16'(i), rd);
      check($sformatf("buf_%0d", i), {8'd0, rd}, {8'd0, f_uni[i]});
    end

    cpu_write(16'hFB00, 8'hFE);
    cpu_read(16'hFB00, rd); check("cr_cleared", {8'd0, rd}, 16'h0000);

    send_frame(f_bc, 12);
    cpu_read(16'hFB00, rd); check("cr_broadcast", {8'd0, rd}, {15'd0, BCAST});
    if (BCAST) begin
      cpu_read(16'hFB02, rd); check("len_lo_broadcast", {8'd0, rd}, 16'h000B);
      cpu_read(16'hF00A, rd); check("buf_10_broadcast", {8'd0, rd}, 16'h0012);
      cpu_read(16'hF00B, rd); check("buf_11_broadcast", {8'd0, rd}, 16'h0034);
    end
    cpu_write(16'hFB00, 8'hFE);

    send_frame(f_oth, 10);
    cpu_read(16'hFB00, rd); check("cr_other_station", {8'd0, rd}, 16'h0000);

    send_frame(f_uni, 10);
    cpu_read(16'hFB00, rd); check("cr_refill", {8'd0, rd}, 16'h0001);
    cpu_write(16'hFB00, 8'h01);
    cpu_read(16'hFB00, rd); check("cr_write_bit0_set", {8'd0, rd}, 16'h0001);
    cpu_write(16'hFB02, 8'h00);
    cpu_read(16'hFB02, rd); check("len_lo_write_ignored", {8'd0, rd}, 16'h0009);

    send_frame(f_two, 12);
    cpu_read(16'hFB00, rd); check("cr_while_full", {8'd0, rd}, 16'h0001);
    cpu_read(16'hFB02, rd); check("len_lo_while_full", {8'd0, rd}, 16'h0009);
    for (int i = 6; i < 10; i++) begin
      cpu_read(16'hF000 + 16'(i), rd);
      check($sformatf("buf_%0d_while_full", i), {8'd0, rd}, {8'd0, f_uni[i]});
    end

    cpu_write(16'hFB00, 8'hFE);
    cpu_read(16'hFB00, rd); check("cr_final_clear", {8'd0, rd}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
